// File: rtl/pong_pkg.sv
// pong_pkg: state encoding, pixel colour type and palette shared by the pong engine.
package pong_pkg;
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAME_OVER} state_e;
  typedef logic [11:0] rgb_t;
  localparam rgb_t C_BLACK  = 12'h000;
  localparam rgb_t C_BORDER = 12'hFF0;
  localparam rgb_t C_PAD1   = 12'h6A2;
  localparam rgb_t C_PAD2   = 12'hA5C;
  localparam rgb_t C_BALL   = 12'hF0F;
endpackage

// File: rtl/pong_paddle.sv
// pong_paddle: one vertical paddle moved per frame tick, clamped inside the border,
// plus its pixel-hit flag for the current (x, y).
module pong_paddle #(
  parameter int X      = 40,
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 90,
  parameter int VEL    = 2,
  parameter int V_RES  = 480,
  parameter int BORDER = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       enable,
  input  logic       up,
  input  logic       down,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] top,
  output logic       on
);
  localparam logic [9:0] TOP0   = 10'((V_RES - HEIGHT) / 2);
  localparam logic [9:0] UP_MIN = 10'(BORDER + VEL);
  localparam logic [9:0] DN_MAX = 10'(V_RES - BORDER - HEIGHT - VEL);
  localparam logic [9:0] STEP   = 10'(VEL);
  localparam logic [9:0] XL     = 10'(X);
  localparam logic [9:0] XR     = 10'(X + WIDTH - 1);
  localparam logic [9:0] HM1    = 10'(HEIGHT - 1);
  logic [9:0] top_q, top_d;
  logic mv;
  always_comb begin
    mv = tick && enable && (up != down);
    top_d = (mv && up && top_q >= UP_MIN) ? top_q - STEP :
            (mv && down && top_q <= DN_MAX) ? top_q + STEP : top_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) top_q <= TOP0;
    else top_q <= top_d;
  assign top = top_q;
  assign on = x >= XL && x <= XR && y >= top_q && y <= top_q + HM1;
endmodule

// File: rtl/pong_game_engine.sv
// pong_game_engine: game FSM, ball physics, scores and per-pixel colour for single-screen pong.
// Define AI_PADDLE2_EN to have paddle 2 track the ball instead of following up2/down2.
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int TICK_LINE    = 481,
  parameter int BORDER       = 5,
  parameter int PAD_WIDTH    = 4,
  parameter int PAD_HEIGHT   = 90,
  parameter int PAD1_X       = 40,
  parameter int PAD2_X       = 600,
  parameter int PAD_VEL      = 2,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               up1,
  input  logic               down1,
  input  logic               up2,
  input  logic               down2,
  input  logic               start,
  input  logic               video_on,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic [11:0]        rgb,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               winner,
  output logic               border_on,
  output logic               pad1_on,
  output logic               pad2_on,
  output logic               ball_on
);
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [9:0] CX  = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0] CY  = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0] BS1 = 10'(BALL_SIZE - 1);
  localparam logic [9:0] SPD = 10'(BALL_SPEED);
  localparam logic [9:0] BRD = 10'(BORDER);
  localparam logic [9:0] RGT = 10'(H_RES - 1 - BORDER);
  localparam logic [9:0] BOT = 10'(V_RES - 1 - BORDER);
  localparam logic [9:0] P1L = 10'(PAD1_X);
  localparam logic [9:0] P1R = 10'(PAD1_X + PAD_WIDTH - 1);
  localparam logic [9:0] P2L = 10'(PAD2_X);
  localparam logic [9:0] P2R = 10'(PAD2_X + PAD_WIDTH - 1);
  localparam logic [9:0] PH1 = 10'(PAD_HEIGHT - 1);
  localparam logic [9:0] TL  = 10'(TICK_LINE);
  localparam logic [CNT_W-1:0] SF = CNT_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_e state_q, state_d;
  logic [9:0] bx_q, bx_d, by_q, by_d, bx_r, by_b, p1_top, p2_top;
  logic dxn_q, dxn_d, dyn_q, dyn_d, pt2_q, pt2_d, win_q, win_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d, sc_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic tick, pad_en, hit1, hit2, miss1, miss2, dxn_n, dyn_n, u2, d2, in_ball, corner;

  assign tick = y == TL && x == 10'd0;
  assign pad_en = state_q != GAME_OVER;

`ifdef AI_PADDLE2_EN
  logic [9:0] ball_c, pad_c;
  logic unused_btn;
  assign unused_btn = up2 | down2;
  assign ball_c = by_q + 10'(BALL_SIZE / 2);
  assign pad_c = p2_top + 10'(PAD_HEIGHT / 2);
  assign u2 = ball_c < pad_c - 10'(PAD_VEL);
  assign d2 = ball_c > pad_c + 10'(PAD_VEL);
`else
  assign u2 = up2;
  assign d2 = down2;
`endif

  pong_paddle #(.X(PAD1_X), .WIDTH(PAD_WIDTH), .HEIGHT(PAD_HEIGHT), .VEL(PAD_VEL),
                .V_RES(V_RES), .BORDER(BORDER)) u_pad1 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .enable(pad_en), .up(up1), .down(down1),
    .x(x), .y(y), .top(p1_top), .on(pad1_on));
  pong_paddle #(.X(PAD2_X), .WIDTH(PAD_WIDTH), .HEIGHT(PAD_HEIGHT), .VEL(PAD_VEL),
                .V_RES(V_RES), .BORDER(BORDER)) u_pad2 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .enable(pad_en), .up(u2), .down(d2),
    .x(x), .y(y), .top(p2_top), .on(pad2_on));

  always_comb begin
    bx_r = bx_q + BS1;
    by_b = by_q + BS1;
    hit1 = dxn_q && bx_q >= P1L && bx_q <= P1R && by_q <= p1_top + PH1 && by_b >= p1_top;
    hit2 = !dxn_q && bx_r >= P2L && bx_r <= P2R && by_q <= p2_top + PH1 && by_b >= p2_top;
    miss2 = !hit1 && !hit2 && bx_q <= BRD;
    miss1 = !hit1 && !hit2 && !miss2 && bx_r >= RGT;
    dxn_n = hit1 ? 1'b0 : hit2 ? 1'b1 : dxn_q;
    dyn_n = (dyn_q && by_q <= BRD) ? 1'b0 : (!dyn_q && by_b >= BOT) ? 1'b1 : dyn_q;
    sc_n = (pt2_q ? s2_q : s1_q) + SCORE_W'(1);
    state_d = state_q;
    bx_d = bx_q;
    by_d = by_q;
    dxn_d = dxn_q;
    dyn_d = dyn_q;
    pt2_d = pt2_q;
    win_d = win_q;
    s1_d = s1_q;
    s2_d = s2_q;
    cnt_d = cnt_q;
    if (tick) begin
      case (state_q)
        IDLE: if (start) begin
          state_d = SERVE;
          cnt_d = SF;
        end
        SERVE: if (cnt_q == '0) state_d = PLAY;
               else cnt_d = cnt_q - CNT_W'(1);
        PLAY: begin
          dxn_d = dxn_n;
          dyn_d = dyn_n;
          if (miss1 || miss2) begin
            state_d = POINT;
            pt2_d = miss2;
          end else begin
            bx_d = dxn_n ? bx_q - SPD : bx_q + SPD;
            by_d = dyn_n ? by_q - SPD : by_q + SPD;
          end
        end
        // serve heads toward whoever conceded: dx negative when player 2 scored
        POINT: begin
          bx_d = CX;
          by_d = CY;
          dxn_d = pt2_q;
          s1_d = pt2_q ? s1_q : sc_n;
          s2_d = pt2_q ? sc_n : s2_q;
          state_d = sc_n == WIN ? GAME_OVER : SERVE;
          win_d = sc_n == WIN ? pt2_q : win_q;
          cnt_d = SF;
        end
        GAME_OVER: if (start) begin
          state_d = SERVE;
          cnt_d = SF;
          s1_d = '0;
          s2_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ball = x >= bx_q && x <= bx_r && y >= by_q && y <= by_b;
    corner = (x == bx_q || x == bx_r) && (y == by_q || y == by_b);
    ball_on = in_ball && !corner && state_q != GAME_OVER;
    border_on = x < BRD || x > RGT || y < BRD || y > BOT;
    rgb = !video_on ? C_BLACK : border_on ? C_BORDER : pad1_on ? C_PAD1 :
          pad2_on ? C_PAD2 : ball_on ? C_BALL : C_BLACK;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      bx_q <= CX;
      by_q <= CY;
      dxn_q <= 1'b0;
      dyn_q <= 1'b0;
      pt2_q <= 1'b0;
      win_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      bx_q <= bx_d;
      by_q <= by_d;
      dxn_q <= dxn_d;
      dyn_q <= dyn_d;
      pt2_q <= pt2_d;
      win_q <= win_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      cnt_q <= cnt_d;
    end

  assign score1 = s1_q;
  assign score2 = s2_q;
  assign game_over = state_q == GAME_OVER;
  assign winner = win_q;
endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine: randomized play against a frame-level game model; pixel probes
// are queued with their expected response and checked by an independent monitor.
module tb_pong_game_engine;
  localparam int HR = 640, VR = 480, BRD = 5, PW = 4, PH = 90, P1X = 40, P2X = 600;
  localparam int PV = 2, BS = 8, SPD = 2, SFR = 60, WINS = 7;

  logic clk = 0, reset_n = 0, up1 = 0, down1 = 0, up2 = 0, down2 = 0, start = 0, video_on = 0;
  logic [9:0] x = 0, y = 0;
  logic [11:0] rgb;
  logic [3:0] score1, score2;
  logic game_over, winner, border_on, pad1_on, pad2_on, ball_on;
  logic [25:0] got;
  logic probe_v = 0;
  int errors = 0, checks = 0;

  typedef struct { logic [25:0] v; int px; int py; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  // game model: 0 idle, 1 serve, 2 play, 3 point, 4 game over
  int m_st, bx, by, dx, dy, p1, p2, s1, s2, cnt, win, scorer;
  bit u1v, d1v, u2v, d2v;
  int bc;

  always #5 clk = ~clk;

  pong_game_engine dut (
    .clk(clk), .reset_n(reset_n), .up1(up1), .down1(down1), .up2(up2), .down2(down2),
    .start(start), .video_on(video_on), .x(x), .y(y), .rgb(rgb), .score1(score1),
    .score2(score2), .game_over(game_over), .winner(winner), .border_on(border_on),
    .pad1_on(pad1_on), .pad2_on(pad2_on), .ball_on(ball_on));

  assign got = {rgb, border_on, pad1_on, pad2_on, ball_on, score1, score2, game_over, winner};

  always @(negedge clk)
    if (probe_v) begin
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard_underflow got=%h", got);
      end else begin
        mon_e = q.pop_front();
        checks++;
        if (got !== mon_e.v) begin
          errors++;
          $display("FAIL probe(%0d,%0d) got=%h exp=%h", mon_e.px, mon_e.py, got, mon_e.v);
        end
      end
    end

  task automatic m_reset();
    m_st = 0; bx = (HR - BS) / 2; by = (VR - BS) / 2; dx = SPD; dy = SPD;
    p1 = (VR - PH) / 2; p2 = (VR - PH) / 2; s1 = 0; s2 = 0; cnt = 0; win = 0; scorer = 0;
  endtask

  function automatic bit ovl(int b, int p);
    return b <= p + PH - 1 && b + BS - 1 >= p;
  endfunction

  function automatic int pmove(int p, bit u, bit d);
    if (u && !d && p >= BRD + PV) return p - PV;
    if (d && !u && p + PH - 1 + PV <= VR - 1 - BRD) return p + PV;
    return p;
  endfunction

  function automatic void m_tick(bit st, bit a1, bit b1, bit a2, bit b2);
    int old = m_st;
    bit hit = 0;
    case (m_st)
      0: if (st) begin m_st = 1; cnt = SFR; end
      1: if (cnt == 0) m_st = 2; else cnt--;
      2: begin
        if (by <= BRD && dy < 0) dy = SPD;
        else if (by + BS - 1 >= VR - 1 - BRD && dy > 0) dy = -SPD;
        if (dx < 0 && bx >= P1X && bx <= P1X + PW - 1 && ovl(by, p1)) begin dx = SPD; hit = 1; end
        else if (dx > 0 && bx + BS - 1 >= P2X && bx + BS - 1 <= P2X + PW - 1 && ovl(by, p2)) begin
          dx = -SPD; hit = 1;
        end
        if (!hit && bx <= BRD) begin scorer = 2; m_st = 3; end
        else if (!hit && bx + BS - 1 >= HR - 1 - BRD) begin scorer = 1; m_st = 3; end
        else begin bx += dx; by += dy; end
      end
      3: begin
        bx = (HR - BS) / 2; by = (VR - BS) / 2;
        dx = (scorer == 1) ? SPD : -SPD;
        if (scorer == 1) s1++; else s2++;
        if (s1 == WINS || s2 == WINS) begin m_st = 4; win = (scorer == 2); end
        else begin m_st = 1; cnt = SFR; end
      end
      default: if (st) begin s1 = 0; s2 = 0; m_st = 1; cnt = SFR; end
    endcase
    if (old != 4) begin p1 = pmove(p1, a1, b1); p2 = pmove(p2, a2, b2); end
  endfunction

  function automatic logic [25:0] exp_vec(int px, int py, bit vo);
    bit bo = px < BRD || px > HR - 1 - BRD || py < BRD || py > VR - 1 - BRD;
    bit a1 = px >= P1X && px <= P1X + PW - 1 && py >= p1 && py <= p1 + PH - 1;
    bit a2 = px >= P2X && px <= P2X + PW - 1 && py >= p2 && py <= p2 + PH - 1;
    bit inb = px >= bx && px <= bx + BS - 1 && py >= by && py <= by + BS - 1;
    bit cor = (px == bx || px == bx + BS - 1) && (py == by || py == by + BS - 1);
    bit bl = inb && !cor && m_st != 4;
    logic [11:0] c = !vo ? 12'h000 : bo ? 12'hFF0 : a1 ? 12'h6A2 : a2 ? 12'hA5C : bl ? 12'hF0F : 12'h000;
    return {c, bo, a1, a2, bl, 4'(s1), 4'(s2), m_st == 4, 1'(win)};
  endfunction

  task automatic probe_now(input int px, input int py, input bit vo);
    x = 10'(px); y = 10'(py); video_on = vo; probe_v = 1;
    q.push_back('{exp_vec(px, py, vo), px, py});
  endtask

  task automatic probe(input int px, input int py, input bit vo);
    @(posedge clk); #1;
    probe_now(px, py, vo);
  endtask

  task automatic do_tick(input bit st, input bit a1, input bit b1, input bit a2, input bit b2);
    @(posedge clk); #1;
    probe_v = 0; x = 0; y = 10'd481; start = st; up1 = a1; down1 = b1; up2 = a2; down2 = b2;
    m_tick(st, a1, b1, a2, b2);
  endtask

  task automatic probes();
    probe(bx + 1, by + 1, 1);
    probe(bx, by, 1);
    probe($urandom_range(659, 0), $urandom_range(489, 0), 1'($urandom_range(1, 0)));
  endtask

  task automatic pad_probes();
    probe(P1X + 1, p1, 1);
    probe(P1X + PW - 1, p1 + PH - 1, 1);
    probe(P1X + 2, p1 - 1, 1);
    probe(P2X, p2, 1);
    probe(P2X + PW - 1, p2 + PH, 1);
  endtask

  task automatic reset_probes();
    probe(2, 2, 1);
    probe(bx + 1, by + 1, 1);
    probe(bx, by, 1);
    pad_probes();
    probe(320, 0, 0);
  endtask

  initial begin
    m_reset();
    reset_probes();
    @(posedge clk); #1;
    reset_n = 1;
    probe_now(2, 2, 1);
    reset_probes();
    // paddle clamps: p1 held up past the top, then both buttons, p2 held down past the bottom
    for (int i = 0; i < 100; i++) begin
      do_tick(0, 1, 0, 0, 0);
      probes();
      if (i % 16 == 0) pad_probes();
    end
    pad_probes();
    for (int i = 0; i < 10; i++) begin
      do_tick(0, 1, 1, 1, 1);
      pad_probes();
    end
    for (int i = 0; i < 100; i++) begin
      do_tick(0, 0, 0, 0, 1);
      probes();
    end
    pad_probes();
    // p1 tracks the ball, p2 flees it, until someone wins
    do_tick(1, 0, 0, 0, 0);
    probes();
    for (int i = 0; i < 6000 && m_st != 4; i++) begin
      bc = by + BS / 2;
      u1v = bc < p1 + PH / 2 - 1; d1v = bc > p1 + PH / 2 + 1;
      d2v = bc < p2 + PH / 2; u2v = !d2v;
      do_tick(0, u1v, d1v, u2v, d2v);
      probes();
      if (i % 16 == 0) pad_probes();
    end
    checks++;
    if (m_st != 4) begin
      errors++;
      $display("FAIL game_over_timeout state=%0d score=%0d:%0d", m_st, s1, s2);
    end
    for (int i = 0; i < 5; i++) begin
      do_tick(0, 1, 0, 0, 1);
      probes();
      pad_probes();
    end
    do_tick(1, 0, 0, 0, 0);
    probes();
    pad_probes();
    // random play until a few points are on the board, then async reset mid-rally
    for (int i = 0; i < 5000 && !(m_st == 2 && s1 + s2 >= 3); i++) begin
      do_tick(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      probes();
      if (i % 16 == 0) pad_probes();
    end
    @(posedge clk); #1;
    reset_n = 0;
    m_reset();
    probe_now(bx + 1, by + 1, 1);
    reset_probes();
    @(posedge clk); #1;
    reset_n = 1;
    probe_now(P1X + 1, p1, 1);
    for (int i = 0; i < 80; i++) begin
      do_tick(i == 0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      probes();
    end
    @(posedge clk); #1;
    probe_v = 0; y = 0;
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
